// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_ctrl
// Purpose  : Top-level sequencer for the helicopter game.
//            - IDLE/PLAY/PAUSE/CRASH/OVER state machine
//            - level-dependent scroll frame tick
//            - score-increment pulse every TICKS_PER_POINT frame ticks
//            - one-cycle restart clear on a new game
//            - timed crash flash followed by game over
// Ports    : clk          in   system clock, rising edge
//            resetn       in   asynchronous active-low reset
//            start        in   start request, rising edge acts
//            pause        in   pause toggle, rising edge acts
//            collision    in   level-sensitive collision flag
//            level [2:0]  in   current level from the levels block
//            game_enable  out  high only while in PLAY
//            frame_tick   out  one-cycle scroll pulse
//            score_inc    out  one-cycle score +1 pulse
//            clear        out  one-cycle restart pulse
//            crash_flash  out  high throughout CRASH
//            state [2:0]  out  IDLE=0 PLAY=1 PAUSE=2 CRASH=3 OVER=4
// Revision : 1.0  initial release
// ============================================================================
module game_ctrl #(
    parameter int CNT_W           = 27,
    parameter int BASE_DIV        = 2_500_000,
    parameter int DIV_STEP        = 300_000,
    parameter int MIN_DIV         = 500_000,
    parameter int TICKS_PER_POINT = 8,
    parameter int CRASH_CYCLES    = 100_000_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       pause,
    input  logic       collision,
    input  logic [2:0] level,
    output logic       game_enable,
    output logic       frame_tick,
    output logic       score_inc,
    output logic       clear,
    output logic       crash_flash,
    output logic [2:0] state
);

    // State encoding (visible on the state port)
    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_PLAY  = 3'd1;
    localparam logic [2:0] c_PAUSE = 3'd2;
    localparam logic [2:0] c_CRASH = 3'd3;
    localparam logic [2:0] c_OVER  = 3'd4;

    // Extra headroom so level*DIV_STEP can never wrap before the clamp test
    localparam int c_RW = CNT_W + 3;
    localparam int c_PW = $clog2(TICKS_PER_POINT + 1);

    localparam logic [CNT_W-1:0] c_ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_BASE       = CNT_W'(BASE_DIV);
    localparam logic [CNT_W-1:0] c_MIN        = CNT_W'(MIN_DIV);
    localparam logic [c_RW-1:0]  c_SPAN       = c_RW'(BASE_DIV - MIN_DIV);
    localparam logic [c_RW-1:0]  c_STEP       = c_RW'(DIV_STEP);
    localparam logic [CNT_W-1:0] c_CRASH_LAST = CNT_W'(CRASH_CYCLES - 1);
    localparam logic [c_PW-1:0]  c_PLAST      = c_PW'(TICKS_PER_POINT - 1);
    localparam logic [c_PW-1:0]  c_PONE       = c_PW'(1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]       r_state;
    logic             r_start_q;
    logic             r_pause_q;
    logic [CNT_W-1:0] r_fcnt;
    logic [c_PW-1:0]  r_pcnt;
    logic [CNT_W-1:0] r_ccnt;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic             w_start_rise;
    logic             w_pause_rise;
    logic [c_RW-1:0]  w_red;
    logic [CNT_W-1:0] w_period;
    logic [CNT_W-1:0] w_period_m1;
    logic             w_tick;
    logic             w_inc;
    logic [2:0]       w_next;
    logic             w_enter;

    assign w_start_rise = start & ~r_start_q;
    assign w_pause_rise = pause & ~r_pause_q;

    // Frame period shrinks by DIV_STEP per level, clamped at MIN_DIV.
    // The clamp test happens before the subtraction, so no underflow.
    assign w_red       = c_RW'(level) * c_STEP;
    assign w_period    = (w_red >= c_SPAN) ? c_MIN : (c_BASE - w_red[CNT_W-1:0]);
    assign w_period_m1 = w_period - c_ONE;

    // ">=" rather than "==" so a level increase that drops the period below
    // the running count fires on the very next cycle instead of wrapping.
    assign w_tick = (r_state == c_PLAY) && (r_fcnt >= w_period_m1);
    assign w_inc  = w_tick && (r_pcnt == c_PLAST);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next  = r_state;
        w_enter = 1'b0;
        case (r_state)
            c_IDLE, c_OVER: begin
                if (w_start_rise) begin
                    w_next  = c_PLAY;
                    w_enter = 1'b1;
                end
            end
            c_PLAY: begin
                // Collision wins over a simultaneous pause request
                if (collision) begin
                    w_next = c_CRASH;
                end else if (w_pause_rise) begin
                    w_next = c_PAUSE;
                end
            end
            c_PAUSE: begin
                if (w_pause_rise) begin
                    w_next = c_PLAY;
                end
            end
            c_CRASH: begin
                if (r_ccnt == c_CRASH_LAST) begin
                    w_next = c_OVER;
                end
            end
            default: begin
                w_next = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= c_IDLE;
            // Held-high inputs across reset release must not look like edges
            r_start_q   <= 1'b1;
            r_pause_q   <= 1'b1;
            r_fcnt      <= '0;
            r_pcnt      <= '0;
            r_ccnt      <= '0;
            game_enable <= 1'b0;
            frame_tick  <= 1'b0;
            score_inc   <= 1'b0;
            clear       <= 1'b0;
            crash_flash <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_start_q <= start;
            r_pause_q <= pause;

            // Frame counter: restarts on a new game, runs only in PLAY,
            // holds in every other state so a resume continues seamlessly.
            if (w_enter) begin
                r_fcnt <= '0;
            end else if (r_state == c_PLAY) begin
                r_fcnt <= w_tick ? '0 : (r_fcnt + c_ONE);
            end

            if (w_enter) begin
                r_pcnt <= '0;
            end else if (w_tick) begin
                r_pcnt <= w_inc ? '0 : (r_pcnt + c_PONE);
            end

            // Held at zero outside CRASH, so it always starts from zero
            if (r_state != c_CRASH) begin
                r_ccnt <= '0;
            end else begin
                r_ccnt <= r_ccnt + c_ONE;
            end

            frame_tick  <= w_tick;
            score_inc   <= w_inc;
            clear       <= w_enter;
            // Based on the next state so these flags line up with state
            game_enable <= (w_next == c_PLAY);
            crash_flash <= (w_next == c_CRASH);
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire
